// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: default geometry, derived
// index/tag widths and the weak counter encodings.
package branch_predictor_pkg;

   localparam int BP_ENTRIES = 16;
   localparam int BP_ADDR_W  = 32;
   localparam int BP_CTR_W   = 2;

   // Index skips the two byte-offset bits; the tag is everything above it.
   localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
   localparam int BP_TAG_W   = BP_ADDR_W - BP_IDX_W - 2;

   // Weak encodings for any counter width up to 4 bits.
   // Weakly-taken has only the MSB set; weakly-not-taken is all ones below it.
   function automatic logic [3:0] weak_taken(input int ctr_w);
      return 4'(1 << (ctr_w - 1));
   endfunction

   function automatic logic [3:0] weak_not_taken(input int ctr_w);
      return 4'((1 << (ctr_w - 1)) - 1);
   endfunction

   localparam logic [BP_CTR_W-1:0] BP_WEAK_T  = BP_CTR_W'(weak_taken(BP_CTR_W));
   localparam logic [BP_CTR_W-1:0] BP_WEAK_NT = BP_CTR_W'(weak_not_taken(BP_CTR_W));

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/decode side bundle of the branch predictor.
// Handshake: update_valid and invalidate are single-cycle strobes with no
// ready; the predictor accepts every strobe on the rising edge it is seen.
// The lookup path is purely combinational and always valid.
interface branch_predictor_if
   import branch_predictor_pkg::*;
#(
   parameter int ADDR_W = BP_ADDR_W
);
   logic [ADDR_W-1:0] lookup_pc;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              update_valid;
   logic [ADDR_W-1:0] update_pc;
   logic              update_taken;
   logic [ADDR_W-1:0] update_target;
   logic              invalidate;
   logic [31:0]       stat_lookups;
   logic [31:0]       stat_hits;

   // Pipeline side: drives PCs and resolutions, consumes predictions.
   modport master (
      output lookup_pc, update_valid, update_pc, update_taken, update_target, invalidate,
      input  pred_taken, pred_target, stat_lookups, stat_hits
   );

   // Predictor side.
   modport slave (
      input  lookup_pc, update_valid, update_pc, update_taken, update_target, invalidate,
      output pred_taken, pred_target, stat_lookups, stat_hits
   );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with a parallel load, one per BTB entry.
// Priority: reset, load, increment, decrement.
module sat_counter #(
   parameter int              CTR_W   = 2,
   parameter logic [CTR_W-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic             i_dec,
   input  logic             i_load,
   input  logic [CTR_W-1:0] i_load_val,
   output logic [CTR_W-1:0] o_cnt
);

   localparam logic [CTR_W-1:0] MAX_VAL = {CTR_W{1'b1}};

   logic [CTR_W-1:0] r_cnt;

   // Count toward the resolved direction, holding at either end.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= RST_VAL;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc) begin
         if (r_cnt != MAX_VAL) r_cnt <= r_cnt + 1'b1;
      end else if (i_dec) begin
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookup is combinational from flops; updates land on the next
// edge, so a same-cycle lookup always sees the pre-update contents.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = BP_ENTRIES,
   parameter int ADDR_W  = BP_ADDR_W,
   parameter int CTR_W   = BP_CTR_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   branch_predictor_if.slave bp
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(weak_taken(CTR_W));
   localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(weak_not_taken(CTR_W));
   localparam logic [31:0]      STAT_MAX = 32'hFFFF_FFFF;

   // Table state
   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [ADDR_W-1:0]  r_target [ENTRIES];
   logic [CTR_W-1:0]   w_ctr    [ENTRIES];

   logic [31:0] r_stat_lookups;
   logic [31:0] r_stat_hits;

   // Lookup port
   logic [IDX_W-1:0]  w_lk_idx;
   logic [TAG_W-1:0]  w_lk_tag;
   logic              w_lk_hit;
   logic              w_lk_taken;

   // Update port, evaluated on pre-update state
   logic [IDX_W-1:0]  w_up_idx;
   logic [TAG_W-1:0]  w_up_tag;
   logic              w_up_hit;
   logic              w_up_pred_taken;
   logic [ADDR_W-1:0] w_up_pred_target;
   logic              w_up_correct;
   logic              w_upd_en;
   logic              w_alloc;

   // Byte-offset bits never participate in indexing or tagging.
   logic w_unused_lsbs;
   assign w_unused_lsbs = ^{bp.lookup_pc[1:0], bp.update_pc[1:0]};

   // Prediction for the fetch PC.
   always_comb begin
      w_lk_idx   = bp.lookup_pc[IDX_W+1:2];
      w_lk_tag   = bp.lookup_pc[ADDR_W-1:IDX_W+2];
      w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
      w_lk_taken = w_lk_hit && w_ctr[w_lk_idx][CTR_W-1];
   end

   assign bp.pred_taken  = w_lk_taken;
   assign bp.pred_target = w_lk_taken ? r_target[w_lk_idx] : (bp.lookup_pc + ADDR_W'(4));

   // What the table would have predicted for the resolved PC, and whether
   // that matched the resolution. Invalidate suppresses the whole update.
   always_comb begin
      w_up_idx         = bp.update_pc[IDX_W+1:2];
      w_up_tag         = bp.update_pc[ADDR_W-1:IDX_W+2];
      w_up_hit         = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
      w_up_pred_taken  = w_up_hit && w_ctr[w_up_idx][CTR_W-1];
      w_up_pred_target = w_up_pred_taken ? r_target[w_up_idx] : (bp.update_pc + ADDR_W'(4));
      w_up_correct     = (w_up_pred_taken == bp.update_taken) &&
                         (!bp.update_taken || (w_up_pred_target == bp.update_target));
      w_upd_en         = bp.update_valid && !bp.invalidate;
      w_alloc          = w_upd_en && !w_up_hit && bp.update_taken;
   end

   // One counter per entry; a miss that resolves taken reloads it weakly taken.
   for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
      logic w_sel;
      assign w_sel = (w_up_idx == IDX_W'(g));

      sat_counter #(
         .CTR_W   (CTR_W),
         .RST_VAL (WEAK_NT)
      ) u_ctr (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_inc      (w_upd_en && w_sel && w_up_hit && bp.update_taken),
         .i_dec      (w_upd_en && w_sel && w_up_hit && !bp.update_taken),
         .i_load     (w_alloc && w_sel),
         .i_load_val (WEAK_T),
         .o_cnt      (w_ctr[g])
      );
   end

   // Valid/tag/target: taken resolutions write the target; misses also claim the entry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
         end
      end else if (bp.invalidate) begin
         r_valid <= '0;
      end else if (w_upd_en && bp.update_taken) begin
         r_target[w_up_idx] <= bp.update_target;
         if (!w_up_hit) begin
            r_valid[w_up_idx] <= 1'b1;
            r_tag[w_up_idx]   <= w_up_tag;
         end
      end
   end

   // Accuracy statistics, saturating; an invalidated update is not counted.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stat_lookups <= '0;
         r_stat_hits    <= '0;
      end else if (w_upd_en) begin
         if (r_stat_lookups != STAT_MAX) r_stat_lookups <= r_stat_lookups + 32'd1;
         if (w_up_correct && (r_stat_hits != STAT_MAX)) r_stat_hits <= r_stat_hits + 32'd1;
      end
   end

   assign bp.stat_lookups = r_stat_lookups;
   assign bp.stat_hits    = r_stat_hits;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16, ADDR_W=32, CTR_W=2).
module tb_branch_predictor;

   logic clk;
   logic rst;

   branch_predictor_if #(.ADDR_W(32)) bp_if ();

   branch_predictor #(
      .ENTRIES (16),
      .ADDR_W  (32),
      .CTR_W   (2)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bp    (bp_if)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit          m_valid  [16];
   logic [25:0] m_tag    [16];
   logic [31:0] m_target [16];
   logic [1:0]  m_ctr    [16];
   logic [31:0] m_lookups;
   logic [31:0] m_hits;

   // Scoreboard queues: prediction {taken, target} and stats {lookups, hits}
   logic [32:0] exp_q[$];
   logic [63:0] exp_stat_q[$];

   // Last observed outputs, for directed checks
   logic        obs_taken;
   logic [31:0] obs_target;
   logic [31:0] obs_lookups;
   logic [31:0] obs_hits;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_predict(input logic [31:0] pc, output logic taken,
                                         output logic [31:0] target);
      logic [3:0] idx;
      logic       hit;
      idx    = pc[5:2];
      hit    = m_valid[idx] && (m_tag[idx] == pc[31:6]);
      taken  = hit && m_ctr[idx][1];
      target = taken ? m_target[idx] : pc + 32'd4;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = '0;
         m_target[i] = '0;
         m_ctr[i]    = 2'b01;
      end
      m_lookups = '0;
      m_hits    = '0;
   endfunction

   function automatic void model_update(input logic uv, input logic [31:0] upc, input logic ut,
                                        input logic [31:0] utgt, input logic inv,
                                        input logic rst_in);
      logic [3:0]  idx;
      logic        hit;
      logic        p_taken;
      logic [31:0] p_target;
      if (rst_in) begin
         model_reset();
         return;
      end
      if (inv) begin
         for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
         return;
      end
      if (!uv) return;
      idx = upc[5:2];
      hit = m_valid[idx] && (m_tag[idx] == upc[31:6]);
      model_predict(upc, p_taken, p_target);
      if (m_lookups != 32'hFFFF_FFFF) m_lookups++;
      if ((p_taken == ut) && (!ut || p_target == utgt) && m_hits != 32'hFFFF_FFFF) m_hits++;
      if (hit) begin
         if (ut) begin
            if (m_ctr[idx] != 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
            m_target[idx] = utgt;
         end else if (m_ctr[idx] != 2'b00) begin
            m_ctr[idx] = m_ctr[idx] - 2'd1;
         end
      end else if (ut) begin
         m_valid[idx]  = 1'b1;
         m_tag[idx]    = upc[31:6];
         m_target[idx] = utgt;
         m_ctr[idx]    = 2'b10;
      end
   endfunction

   // Driver: one clock cycle of stimulus; expected outputs are queued on drive
   // and compared mid-cycle, then the model advances with the edge.
   task automatic step(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic inv,
                       input logic rst_in);
      logic        e_taken;
      logic [31:0] e_target;
      logic [32:0] e_pred;
      logic [63:0] e_stat;
      bp_if.lookup_pc     = lpc;
      bp_if.update_valid  = uv;
      bp_if.update_pc     = upc;
      bp_if.update_taken  = ut;
      bp_if.update_target = utgt;
      bp_if.invalidate    = inv;
      rst                 = rst_in;
      model_predict(lpc, e_taken, e_target);
      exp_q.push_back({e_taken, e_target});
      exp_stat_q.push_back({m_lookups, m_hits});
      @(negedge clk);
      e_pred = exp_q.pop_front();
      e_stat = exp_stat_q.pop_front();
      obs_taken   = bp_if.pred_taken;
      obs_target  = bp_if.pred_target;
      obs_lookups = bp_if.stat_lookups;
      obs_hits    = bp_if.stat_hits;
      check("pred_taken",   64'(obs_taken),   64'(e_pred[32]));
      check("pred_target",  64'(obs_target),  64'(e_pred[31:0]));
      check("stat_lookups", 64'(obs_lookups), 64'(e_stat[63:32]));
      check("stat_hits",    64'(obs_hits),    64'(e_stat[31:0]));
      @(posedge clk);
      model_update(uv, upc, ut, utgt, inv, rst_in);
      #1;
   endtask

   task automatic lookup_only(input logic [31:0] lpc);
      step(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic update(input logic [31:0] lpc, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt);
      step(lpc, 1'b1, upc, ut, utgt, 1'b0, 1'b0);
   endtask

   localparam logic [31:0] PC_A  = 32'h0040_0020;
   localparam logic [31:0] PC_B  = 32'h0040_0060;
   localparam logic [31:0] TGT_A = 32'h0040_0000;
   localparam logic [31:0] TGT_B = 32'h0040_0100;

   initial begin
      logic [31:0] r_pc;
      logic [31:0] r_lpc;
      rst                 = 1'b1;
      bp_if.lookup_pc     = '0;
      bp_if.update_valid  = 1'b0;
      bp_if.update_pc     = '0;
      bp_if.update_taken  = 1'b0;
      bp_if.update_target = '0;
      bp_if.invalidate    = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;

      // Reset state
      lookup_only(32'h0040_0010);
      check("rst_taken",   64'(obs_taken),   64'(0));
      check("rst_target",  64'(obs_target),  64'(32'h0040_0014));
      check("rst_lookups", 64'(obs_lookups), 64'(0));
      check("rst_hits",    64'(obs_hits),    64'(0));

      // First taken update with a same-cycle lookup of the same PC
      update(PC_A, PC_A, 1'b1, TGT_A);
      check("same_cycle_taken", 64'(obs_taken), 64'(0));
      lookup_only(PC_A);
      check("alloc_taken",   64'(obs_taken),   64'(1));
      check("alloc_target",  64'(obs_target),  64'(TGT_A));
      check("alloc_lookups", 64'(obs_lookups), 64'(1));
      check("alloc_hits",    64'(obs_hits),    64'(0));

      // Two not-taken: 10 -> 01 -> 00
      update(PC_A, PC_A, 1'b0, TGT_A);
      update(PC_A, PC_A, 1'b0, TGT_A);
      lookup_only(PC_A);
      check("ctr00_taken",  64'(obs_taken),  64'(0));
      check("ctr00_target", 64'(obs_target), 64'(PC_A + 32'd4));

      // Four taken: 00 -> 01 -> 10 -> 11 -> 11
      for (int i = 0; i < 4; i++) update(PC_A, PC_A, 1'b1, TGT_A);
      lookup_only(PC_A);
      check("ctr11_taken", 64'(obs_taken), 64'(1));
      // From saturated 11 one not-taken still predicts taken
      update(PC_A, PC_A, 1'b0, TGT_A);
      lookup_only(PC_A);
      check("ctr10_taken", 64'(obs_taken), 64'(1));

      // Alias on index 8 with a different tag
      lookup_only(PC_B);
      check("alias_miss_taken",  64'(obs_taken),  64'(0));
      check("alias_miss_target", 64'(obs_target), 64'(PC_B + 32'd4));
      update(PC_B, PC_B, 1'b1, TGT_B);
      lookup_only(PC_B);
      check("alias_new_taken",  64'(obs_taken),  64'(1));
      check("alias_new_target", 64'(obs_target), 64'(TGT_B));
      lookup_only(PC_A);
      check("alias_old_taken",  64'(obs_taken),  64'(0));
      check("alias_old_target", 64'(obs_target), 64'(PC_A + 32'd4));

      // Invalidate beats a simultaneous update; stats frozen
      step(PC_B, 1'b1, PC_A, 1'b1, TGT_A, 1'b1, 1'b0);
      lookup_only(PC_B);
      check("inv_taken",   64'(obs_taken),   64'(0));
      check("inv_lookups", 64'(obs_lookups), 64'(9));
      check("inv_hits",    64'(obs_hits),    64'(3));
      lookup_only(PC_A);
      check("inv_a_taken", 64'(obs_taken), 64'(0));

      // Reset beats a simultaneous update
      update(PC_B, PC_B, 1'b1, TGT_B);
      step(PC_A, 1'b1, PC_A, 1'b1, TGT_A, 1'b0, 1'b1);
      lookup_only(PC_A);
      check("rstupd_taken",   64'(obs_taken),   64'(0));
      check("rstupd_lookups", 64'(obs_lookups), 64'(0));
      lookup_only(PC_B);
      check("rstupd_b_taken", 64'(obs_taken), 64'(0));

      // Random traffic on a small aliasing PC set
      for (int n = 0; n < 400; n++) begin
         r_pc  = 32'h0040_0000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
         r_lpc = 32'h0040_0000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
         if ($urandom_range(0, 1) == 1) r_lpc = r_pc;
         step(r_lpc,
              1'($urandom_range(0, 3) != 0),
              r_pc,
              1'($urandom_range(0, 1)),
              32'h0040_1000 + (32'($urandom_range(0, 1)) << 4),
              1'($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 149) == 0));
      end

      check("queue_drained", 64'(exp_q.size() + exp_stat_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of BTB entries (power of 2, 4..256).
REQ-002 SHALL have parameter ADDR_W, default 32, PC/target width.
REQ-003 SHALL have parameter CTR_W, default 2, saturating-counter width (1..4).
REQ-004 CLOCK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET  in  1  reset, synchronous, active-high.
REQ-006 lookup_pc  in  ADDR_W  F-stage fetch PC.
REQ-007 pred_taken  out  1  prediction for lookup_pc.
REQ-008 pred_target  out  ADDR_W  predicted next PC.
REQ-009 update_valid  in  1  D-stage resolved control-transfer strobe.
REQ-010 update_pc  in  ADDR_W  PC of the resolved branch/jump.
REQ-011 update_taken  in  1  resolved direction (jumps drive 1).
REQ-012 update_target  in  ADDR_W  resolved taken target.
REQ-013 invalidate  in  1  clear all entries.
REQ-014 stat_lookups  out  32  count of update_valid cycles.
REQ-015 stat_hits  out  32  count of updates whose prediction matched the resolution.

Function
REQ-016 SHALL index with lookup_pc[IDX_W+1:2], IDX_W = log2(ENTRIES); tag = PC[ADDR_W-1:IDX_W+2].
REQ-017 SHALL store per entry: valid, tag, target, CTR_W-bit counter.
REQ-018 Hit = valid AND tag match; lookup SHALL be combinational from registered state, zero latency.
REQ-019 pred_taken = hit AND counter MSB; pred_target = stored target if pred_taken, else lookup_pc+4 (mod 2^ADDR_W).
REQ-020 Update hit: counter +1 if taken (saturate at all-ones), -1 if not taken (saturate at 0); target overwritten only when taken.
REQ-021 Update miss, taken: allocate/replace entry: valid=1, new tag, target, counter = weakly-taken (MSB=1, rest 0).
REQ-022 Update miss, not taken: no table change.
REQ-023 Update and lookup same cycle/same index: lookup SHALL see pre-update contents; new contents visible next cycle.
REQ-024 invalidate SHALL clear all valid bits at next edge; counters/targets untouched; invalidate with update_valid: invalidate wins, update discarded.
REQ-025 Prediction correct = (predicted taken == update_taken) AND (if taken, predicted target == update_target), evaluated on pre-update state of update_pc.
REQ-026 stat_lookups +1 per update_valid cycle; stat_hits +1 per correct prediction; both saturate at 0xFFFFFFFF; stats unaffected by invalidate.

Reset
REQ-027 RESET SHALL clear all valid bits, set counters to weakly-not-taken (MSB=0, rest 1), targets 0, stats 0.
REQ-028 Update/invalidate asserted with RESET SHALL be discarded; RESET wins.
REQ-029 Out of reset: pred_taken=0, pred_target=lookup_pc+4.

Structure
REQ-030 Shared package SHALL hold ENTRIES/ADDR_W/CTR_W defaults, derived IDX_W/TAG_W, weak-taken/weak-not-taken constants.
REQ-031 Saturating counter SHALL be a sub-module sat_counter (CTR_W parameter, inc/dec/load inputs).
REQ-032 Table SHALL be flop-based (no RAM macro) for same-cycle read.

Verification (ENTRIES=16, CTR_W=2)
REQ-033 Reset, lookup 0x00400010 -> pred_taken=0, pred_target=0x00400014, stats 0.
REQ-034 Update 0x00400020 taken ->0x00400000; next cycle lookup 0x00400020 -> pred_taken=1, pred_target=0x00400000, stat_lookups=1, stat_hits=0.
REQ-035 Two not-taken updates of 0x00400020 -> counter 00, pred_taken=0; four taken updates -> counter 11 after third, stays 11.
REQ-036 Alias: entry for 0x00400020 valid, lookup 0x00400060 (index 8, tag differs) -> miss; taken update 0x00400060 ->0x00400100 replaces; 0x00400020 then misses.
REQ-037 Update 0x00400020 taken with lookup 0x00400020 same cycle -> that cycle pred_taken=0; next cycle pred_taken=1.
REQ-038 invalidate with update_valid same cycle -> all lookups miss next cycle, stats unchanged; RESET with update -> table empty.
